imem_dmem_port_arbiter: RTL and testbench
=========================================

Name: imem_dmem_port_arbiter

Overview:
- Shares one single-ported, synchronous-read unified memory between the processor fetch port (IF stage) and the data port (MEM stage).
- Issues at most one memory access per cycle and returns read data one cycle after grant.
- Data accesses have priority; a starvation counter guarantees forward progress for fetch.
- Sits between processor_top and the unified memory model, replacing the separate imem/dmem pair.

Parameters:
- ADDR_W, 64, byte address width of both requester ports.
- MEM_AW, 13, byte address bits forwarded to memory (8 KiB).
- STARVE_LIMIT, 4, consecutive cycles a pending fetch may lose before it is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  ADDR_W  fetch byte address, 4-byte aligned.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  fetch data valid.
- if_rdata  out  32  instruction word.
- d_req  in  1  data request; held until d_gnt.
- d_addr  in  ADDR_W  data byte address.
- d_wen  in  1  1 = store, 0 = load.
- d_wdata  in  64  store data, lane-aligned.
- d_byte_en  in  8  store byte lanes.
- d_gnt  out  1  data access accepted this cycle.
- d_rvalid  out  1  load data valid, or store acknowledge.
- d_rdata  out  64  load doubleword.
- mem_en  out  1  memory access strobe.
- mem_addr  out  MEM_AW  doubleword-aligned address (bits [2:0] = 0).
- mem_wen  out  1  memory write.
- mem_wdata  out  64  memory write data.
- mem_byte_en  out  8  memory write lanes.
- mem_rdata  in  64  read data, valid the cycle after mem_en.

Behaviour:
- Reset: state IDLE, starve_cnt = 0, sel_hi = 0. All outputs 0. Any outstanding response is discarded, so no rvalid is asserted in the first cycle after reset release.
- Grant logic is combinational from requests and starve_cnt:
  - If d_req and not (if_req and starve_cnt == STARVE_LIMIT), grant data.
  - Otherwise, if if_req, grant fetch.
  - Exactly one gnt at a time; never a gnt without the matching req.
- Memory drive on a grant:
  - mem_en = 1 and mem_addr = {granted_addr[MEM_AW-1:3], 3'b000}.
  - For a data grant: mem_wen = d_wen, mem_wdata = d_wdata, mem_byte_en = d_wen ? d_byte_en : 8'h00.
  - For a fetch grant: mem_wen = 0 and mem_byte_en = 0.
  - With no grant, mem_en = 0 and mem_wen = 0.
- Response FSM records the owner of the outstanding access:
  - States: IDLE, RESP_IF, RESP_D.
  - Next state = RESP_D on d_gnt, RESP_IF on if_gnt, otherwise IDLE, from any state. This gives back-to-back grants with no bubble.
- RESP_IF output: if_rvalid = 1 and if_rdata = sel_hi ? mem_rdata[63:32] : mem_rdata[31:0]. sel_hi is if_addr[2], registered at grant.
- RESP_D output:
  - d_rvalid = 1 and d_rdata = mem_rdata; loads only, d_rdata = 0 for stores.
  - A store's d_rvalid is an acknowledge only.
- In IDLE both rvalid outputs = 0 and both rdata outputs = 0.
- Latency: grant in cycle N, response in cycle N+1. Throughput is one access per cycle.
- Starvation counter:
  - Increments, saturating at STARVE_LIMIT, when if_req is high and if_gnt is low.
  - Clears to 0 on if_gnt or when if_req is low.
- Simultaneous requests at the limit: fetch wins, d_gnt = 0, and the data requester holds its request to the next cycle.
- Misalignment:
  - Address bits [2:0] are never forwarded.
  - d_byte_en is passed through unchecked; alignment checking is the data port's responsibility.
  - if_addr[1:0] != 0 is illegal; the bench asserts it and the arbiter behaviour is unspecified.
- Addresses beyond MEM_AW bits wrap modulo 2^MEM_AW.
- Reset asserted mid-access: state returns to IDLE asynchronously and mem_en drops immediately.

Decomposition:
- Add to riscv_pkg:
  - typedef enum logic [1:0] arb_state_e {ARB_IDLE, ARB_RESP_IF, ARB_RESP_D}.
  - Constant ARB_STARVE_LIMIT_DEFAULT = 4.
  - typedef struct mem_req_t {addr, wen, wdata, byte_en} for the muxed request.
- One natural sub-module, arb_starve_counter: the saturating counter plus its limit compare. Everything else stays flat.

Test Plan:
- Fetch-only read:
  - Stimulus: memory holds 0x1122334455667788 at doubleword 0x40; drive if_req with if_addr = 0x44.
  - Response: if_gnt in the same cycle; next cycle if_rvalid = 1 and if_rdata = 0x11223344.
- Data-only store then load:
  - Stimulus: store to 0x1008 with d_wdata = 0x123456789ABCDEF0, byte_en = 0xFF; then load 0x1008.
  - Response: store ack d_rvalid = 1 with d_rdata = 0; load returns d_rdata = 0x123456789ABCDEF0.
- Simultaneous requests:
  - Stimulus: if_req and d_req both high in the same cycle with starve_cnt = 0.
  - Response: d_gnt = 1, if_gnt = 0, starve_cnt = 1; if_gnt is granted the next cycle once d_req drops.
- Starvation:
  - Stimulus: if_req held high and d_req held high for 6 cycles.
  - Response: d_gnt for 4 cycles, if_gnt on cycle 5 with starve_cnt cleared, d_gnt again on cycle 6.
- Back-to-back ownership:
  - Stimulus: d_gnt in cycle N, if_gnt in cycle N+1.
  - Response: d_rvalid in N+1 and if_rvalid in N+2, with no bubble and no overlapping rvalid.
- Reset mid-access:
  - Stimulus: assert rst_n low for one half-cycle immediately after a granted load.
  - Response: mem_en drops immediately; no d_rvalid in the cycle after release; starve_cnt = 0.

Source files
------------

// File: rtl/imem_dmem_port_arbiter_pkg.sv
// Shared types and constants for the unified imem/dmem port arbiter.
package imem_dmem_port_arbiter_pkg;

    // Default number of consecutive lost cycles before a pending fetch is forced through
    localparam int unsigned ARB_STARVE_LIMIT_DEFAULT = 4;
    // Counter width covers the full legal limit range 1..15
    localparam int unsigned ARB_STARVE_CNT_W         = 4;
    // Width of the address carried in the muxed request (widest requester address)
    localparam int unsigned ARB_REQ_ADDR_W           = 64;

    // Owner of the access whose read data returns this cycle
    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_RESP_IF = 2'd1,
        ARB_RESP_D  = 2'd2
    } arb_state_e;

    // Request presented to the unified memory after the grant mux
    typedef struct packed {
        logic [ARB_REQ_ADDR_W-1:0] addr;
        logic                      wen;
        logic [63:0]               wdata;
        logic [7:0]                byte_en;
    } mem_req_t;

endpackage

// File: rtl/imem_dmem_port_arbiter_starve_counter.sv
// Saturating count of cycles a pending fetch has lost arbitration, plus its limit compare.
module imem_dmem_port_arbiter_starve_counter
    import imem_dmem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = ARB_STARVE_LIMIT_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        if_req_i,
    input  logic                        if_gnt_i,
    output logic                        at_limit_o,
    output logic [ARB_STARVE_CNT_W-1:0] cnt_o
);

    localparam logic [ARB_STARVE_CNT_W-1:0] Limit = ARB_STARVE_CNT_W'(STARVE_LIMIT);

    logic [ARB_STARVE_CNT_W-1:0] cnt_d, cnt_q;

    // Count lost fetch cycles; any fetch win or idle fetch port restarts the count
    always_comb begin
        cnt_d = cnt_q;
        if (!if_req_i || if_gnt_i) begin
            cnt_d = '0;
        end else if (cnt_q != Limit) begin
            cnt_d = cnt_q + ARB_STARVE_CNT_W'(1);
        end
    end

    // Counter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit_o = (cnt_q == Limit);
    assign cnt_o      = cnt_q;

endmodule

// File: rtl/imem_dmem_port_arbiter.sv
// Arbitrates the fetch and data ports onto one single-ported synchronous-read memory.
// Data wins by default; a starved fetch is forced through after STARVE_LIMIT losses.
module imem_dmem_port_arbiter
    import imem_dmem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = 64,
    parameter int unsigned MEM_AW       = 13,
    parameter int unsigned STARVE_LIMIT = ARB_STARVE_LIMIT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [31:0]       if_rdata_o,
    input  logic              d_req_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic              d_wen_i,
    input  logic [63:0]       d_wdata_i,
    input  logic [7:0]        d_byte_en_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [63:0]       d_rdata_o,
    output logic              mem_en_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic              mem_wen_o,
    output logic [63:0]       mem_wdata_o,
    output logic [7:0]        mem_byte_en_o,
    input  logic [63:0]       mem_rdata_i
);

    logic                        if_gnt, d_gnt;
    logic                        starve_at_limit;
    logic [ARB_STARVE_CNT_W-1:0] starve_cnt;
    mem_req_t                    mem_req;
    arb_state_e                  state_q;
    logic                        sel_hi_q;
    logic                        resp_wen_q;

    imem_dmem_port_arbiter_starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req_i   (if_req_i),
        .if_gnt_i   (if_gnt),
        .at_limit_o (starve_at_limit),
        .cnt_o      (starve_cnt)
    );

    // Grant: data first unless a fetch has hit the starvation limit; no grant while in reset
    always_comb begin
        d_gnt  = 1'b0;
        if_gnt = 1'b0;
        if (rst_n) begin
            if (d_req_i && !(if_req_i && starve_at_limit)) begin
                d_gnt = 1'b1;
            end else if (if_req_i) begin
                if_gnt = 1'b1;
            end
        end
    end

    // Route the winning requester onto the memory port; all fields idle at zero
    always_comb begin
        mem_req = '0;
        if (d_gnt) begin
            mem_req.addr    = ARB_REQ_ADDR_W'(d_addr_i);
            mem_req.wen     = d_wen_i;
            mem_req.wdata   = d_wdata_i;
            mem_req.byte_en = d_wen_i ? d_byte_en_i : 8'h00;
        end else if (if_gnt) begin
            mem_req.addr = ARB_REQ_ADDR_W'(if_addr_i);
        end
    end

    // High address bits wrap away and the byte offset is never forwarded
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_req.addr[ARB_REQ_ADDR_W-1:MEM_AW], mem_req.addr[2:0]};

    assign if_gnt_o      = if_gnt;
    assign d_gnt_o       = d_gnt;
    assign mem_en_o      = if_gnt | d_gnt;
    assign mem_addr_o    = {mem_req.addr[MEM_AW-1:3], 3'b000};
    assign mem_wen_o     = mem_req.wen;
    assign mem_wdata_o   = mem_req.wdata;
    assign mem_byte_en_o = mem_req.byte_en;

    // Response FSM: remember who owns the read data arriving next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            sel_hi_q   <= 1'b0;
            resp_wen_q <= 1'b0;
        end else begin
            if (d_gnt) begin
                state_q    <= ARB_RESP_D;
                resp_wen_q <= d_wen_i;
            end else if (if_gnt) begin
                state_q  <= ARB_RESP_IF;
                sel_hi_q <= if_addr_i[2];
            end else begin
                state_q <= ARB_IDLE;
            end
        end
    end

    // Steer memory read data to the owner; a store only gets an acknowledge with zero data
    always_comb begin
        if_rvalid_o = 1'b0;
        if_rdata_o  = '0;
        d_rvalid_o  = 1'b0;
        d_rdata_o   = '0;
        unique case (state_q)
            ARB_RESP_IF: begin
                if_rvalid_o = 1'b1;
                if_rdata_o  = sel_hi_q ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
            end
            ARB_RESP_D: begin
                d_rvalid_o = 1'b1;
                d_rdata_o  = resp_wen_q ? 64'h0 : mem_rdata_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// Directed bench: stimulus pushes expected responses into queues, a monitor pops and compares.
module tb_imem_dmem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic [63:0] d_addr;
    logic        d_wen;
    logic [63:0] d_wdata;
    logic [7:0]  d_byte_en;
    logic        d_gnt;
    logic        d_rvalid;
    logic [63:0] d_rdata;
    logic        mem_en;
    logic [12:0] mem_addr;
    logic        mem_wen;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_byte_en;
    logic [63:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    logic [31:0] if_q [$];
    logic [63:0] d_q  [$];

    logic [63:0] mem [0:1023];

    imem_dmem_port_arbiter #(
        .ADDR_W       (64),
        .MEM_AW       (13),
        .STARVE_LIMIT (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_req_i      (if_req),
        .if_addr_i     (if_addr),
        .if_gnt_o      (if_gnt),
        .if_rvalid_o   (if_rvalid),
        .if_rdata_o    (if_rdata),
        .d_req_i       (d_req),
        .d_addr_i      (d_addr),
        .d_wen_i       (d_wen),
        .d_wdata_i     (d_wdata),
        .d_byte_en_i   (d_byte_en),
        .d_gnt_o       (d_gnt),
        .d_rvalid_o    (d_rvalid),
        .d_rdata_o     (d_rdata),
        .mem_en_o      (mem_en),
        .mem_addr_o    (mem_addr),
        .mem_wen_o     (mem_wen),
        .mem_wdata_o   (mem_wdata),
        .mem_byte_en_o (mem_byte_en),
        .mem_rdata_i   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unified memory model: synchronous read, byte-lane writes, preload while in reset
    always @(posedge clk) begin
        if (!rst_n) begin
            mem[8]     <= 64'h1122334455667788;
            mem[10'h201] <= 64'h0;
        end else if (mem_en) begin
            if (mem_wen) begin
                for (int b = 0; b < 8; b++) begin
                    if (mem_byte_en[b]) mem[mem_addr[12:3]][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end else begin
                mem_rdata <= mem[mem_addr[12:3]];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare each presented response against the scoreboard
    initial begin
        logic [31:0] ei;
        logic [63:0] ed;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (if_req && if_addr[1:0] != 2'b00) begin
                    errors++;
                    $display("FAIL if_addr_align: got %h expected low bits 00", if_addr);
                end
                if (if_rvalid && d_rvalid) chk("rvalid_exclusive", 64'(1), 64'(0));
                if (if_rvalid) begin
                    if (if_q.size() == 0) begin
                        chk("if_unexpected_rvalid", 64'(1), 64'(0));
                    end else begin
                        ei = if_q.pop_front();
                        chk("if_rdata", 64'(if_rdata), 64'(ei));
                    end
                end else begin
                    chk("if_rdata_idle", 64'(if_rdata), 64'(0));
                end
                if (d_rvalid) begin
                    if (d_q.size() == 0) begin
                        chk("d_unexpected_rvalid", 64'(1), 64'(0));
                    end else begin
                        ed = d_q.pop_front();
                        chk("d_rdata", d_rdata, ed);
                    end
                end else begin
                    chk("d_rdata_idle", d_rdata, 64'(0));
                end
            end
        end
    end

    // One arbitration cycle: drive, check grants/memory drive/rvalid timing, push expectation
    task automatic cyc(input logic ir, input logic [63:0] ia,
                       input logic dr, input logic [63:0] da, input logic dw,
                       input logic [63:0] wd, input logic [7:0] be,
                       input logic eig, input logic edg, input logic [12:0] eaddr,
                       input logic eirv, input logic edrv, input logic [3:0] ecnt,
                       input logic [63:0] edata);
        @(negedge clk);
        if_req = ir; if_addr = ia;
        d_req = dr; d_addr = da; d_wen = dw; d_wdata = wd; d_byte_en = be;
        #1;
        chk("if_gnt", 64'(if_gnt), 64'(eig));
        chk("d_gnt", 64'(d_gnt), 64'(edg));
        chk("mem_en", 64'(mem_en), 64'(eig | edg));
        chk("mem_wen", 64'(mem_wen), 64'(edg & dw));
        chk("mem_byte_en", 64'(mem_byte_en), 64'((edg & dw) ? be : 8'h00));
        if (eig | edg) chk("mem_addr", 64'(mem_addr), 64'(eaddr));
        if (edg & dw) chk("mem_wdata", mem_wdata, wd);
        chk("if_rvalid", 64'(if_rvalid), 64'(eirv));
        chk("d_rvalid", 64'(d_rvalid), 64'(edrv));
        chk("starve_cnt", 64'(dut.starve_cnt), 64'(ecnt));
        if (eig) if_q.push_back(edata[31:0]);
        if (edg) d_q.push_back(edata);
    endtask

    localparam logic [63:0] DA  = 64'h1008;
    localparam logic [63:0] V1  = 64'h123456789ABCDEF0;
    localparam logic [63:0] V2  = 64'h12345678CAFEF00D;

    initial begin
        rst_n = 1'b0;
        if_req = 1'b1; if_addr = 64'h44;
        d_req = 1'b1; d_addr = DA; d_wen = 1'b0; d_wdata = '0; d_byte_en = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_if_gnt", 64'(if_gnt), 64'(0));
        chk("rst_d_gnt", 64'(d_gnt), 64'(0));
        chk("rst_mem_en", 64'(mem_en), 64'(0));
        chk("rst_rvalid", 64'({if_rvalid, d_rvalid}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1; if_req = 1'b0; d_req = 1'b0;

        //   ir   ia     dr   da    dw    wdata                  be     ig dg addr      irv drv cnt data
        cyc(1'b1, 64'h44, 1'b0, DA, 1'b0, 64'h0,                 8'h00, 1, 0, 13'h040, 0, 0, 0, 64'h11223344);
        cyc(1'b0, 64'h0,  1'b0, DA, 1'b0, 64'h0,                 8'h00, 0, 0, 13'h000, 1, 0, 0, 64'h0);
        cyc(1'b0, 64'h0,  1'b1, DA, 1'b1, V1,                    8'hFF, 0, 1, 13'h1008, 0, 0, 0, 64'h0);
        cyc(1'b0, 64'h0,  1'b1, DA, 1'b0, 64'h0,                 8'hFF, 0, 1, 13'h1008, 0, 1, 0, V1);
        // simultaneous requests: data wins, fetch follows without a bubble
        cyc(1'b1, 64'h44, 1'b1, DA, 1'b0, 64'h0,                 8'h00, 0, 1, 13'h1008, 0, 1, 0, V1);
        cyc(1'b1, 64'h44, 1'b0, DA, 1'b0, 64'h0,                 8'h00, 1, 0, 13'h040, 0, 1, 1, 64'h11223344);
        // starvation: four data wins, forced fetch, then data again
        cyc(1'b1, 64'h40, 1'b1, DA, 1'b0, 64'h0,                 8'h00, 0, 1, 13'h1008, 1, 0, 0, V1);
        cyc(1'b1, 64'h40, 1'b1, DA, 1'b0, 64'h0,                 8'h00, 0, 1, 13'h1008, 0, 1, 1, V1);
        cyc(1'b1, 64'h40, 1'b1, DA, 1'b0, 64'h0,                 8'h00, 0, 1, 13'h1008, 0, 1, 2, V1);
        cyc(1'b1, 64'h40, 1'b1, DA, 1'b0, 64'h0,                 8'h00, 0, 1, 13'h1008, 0, 1, 3, V1);
        cyc(1'b1, 64'h40, 1'b1, DA, 1'b0, 64'h0,                 8'h00, 1, 0, 13'h040, 0, 1, 4, 64'h55667788);
        cyc(1'b1, 64'h40, 1'b1, DA, 1'b0, 64'h0,                 8'h00, 0, 1, 13'h1008, 1, 0, 0, V1);
        cyc(1'b1, 64'h40, 1'b0, DA, 1'b0, 64'h0,                 8'h00, 1, 0, 13'h040, 0, 1, 1, 64'h55667788);
        // partial store, then a load whose address wraps onto the same doubleword
        cyc(1'b0, 64'h0,  1'b1, DA, 1'b1, 64'hDEADBEEFCAFEF00D,  8'h0F, 0, 1, 13'h1008, 1, 0, 0, 64'h0);
        cyc(1'b0, 64'h0,  1'b1, 64'hFFFF000000003008, 1'b0, 64'h0, 8'h00, 0, 1, 13'h1008, 0, 1, 0, V2);
        cyc(1'b0, 64'h0,  1'b0, DA, 1'b0, 64'h0,                 8'h00, 0, 0, 13'h000, 0, 1, 0, 64'h0);

        // reset mid-access: the granted load's response is discarded
        @(negedge clk);
        if_req = 1'b1; if_addr = 64'h44; d_req = 1'b1; d_addr = DA; d_wen = 1'b0;
        #1;
        chk("pre_rst_d_gnt", 64'(d_gnt), 64'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_en", 64'(mem_en), 64'(0));
        chk("midrst_d_gnt", 64'(d_gnt), 64'(0));
        chk("midrst_d_rvalid", 64'(d_rvalid), 64'(0));
        chk("midrst_starve_cnt", 64'(dut.starve_cnt), 64'(0));
        @(negedge clk);
        rst_n = 1'b1; if_req = 1'b0; d_req = 1'b0;

        cyc(1'b0, 64'h0,  1'b0, DA, 1'b0, 64'h0,                 8'h00, 0, 0, 13'h000, 0, 0, 0, 64'h0);
        cyc(1'b1, 64'h40, 1'b0, DA, 1'b0, 64'h0,                 8'h00, 1, 0, 13'h040, 0, 0, 0, 64'h55667788);
        cyc(1'b0, 64'h0,  1'b0, DA, 1'b0, 64'h0,                 8'h00, 0, 0, 13'h000, 1, 0, 0, 64'h0);

        repeat (2) @(negedge clk);
        #1;
        chk("if_q_drained", 64'(if_q.size()), 64'(0));
        chk("d_q_drained", 64'(d_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Bound the run in case the stimulus ever stalls
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
